keypad_encoder: RTL and testbench
=================================

// Module: keypad_encoder
// PURPOSE
//   Sits directly downstream of the per-key debounce stages in the microwave encoder path.
//   Takes the bus of debounced, active-low key levels for digits 0-9.
//   Detects one accepted keystroke per press, waits a settle window, rejects multi-key chords,
//   and presents the digit code to the control FSM through a single-entry valid/ready register.
// PARAMETERS
//   N_KEYS         10  number of key lines; bit i = digit i; must satisfy N_KEYS <= 2**CODE_W
//   CODE_W          4  width of the output digit code (binary index of the pressed key)
//   SETTLE_CYCLES   2  clk cycles between the press being seen and chord evaluation; >= 1
// PORTS
//   clk          in   1       system clock; all state updates on rising edge
//   rst_n        in   1       asynchronous, active-low reset
//   keys_n       in   N_KEYS  debounced key levels, 0 = pressed; synchronous to clk
//   code         out  CODE_W  digit code; stable while code_valid=1
//   code_valid   out  1       code holds an unconsumed keystroke
//   code_ready   in   1       consumer accepts; transfer on edge with code_valid & code_ready
//   multi_err    out  1       1-cycle pulse: more than one key was low at evaluation
//   overrun      out  1       sticky: a valid keystroke was dropped because the register was full
//   clr_overrun  in   1       synchronous clear of overrun
//   busy         out  1       FSM not in IDLE (combinational from state)
// BEHAVIOUR
//   Reset: state=IDLE, keys_q=all 1, cnt=0, code=0, code_valid=0, multi_err=0, overrun=0, busy=0.
//   Input stage: keys_q <= keys_n every edge; no further synchronisation is needed (source is synchronous).
//   FSM states: IDLE, SETTLE, WAIT_REL.
//   - IDLE:     any bit of keys_q = 0 -> SETTLE, cnt <= 0.
//   - SETTLE:   cnt != SETTLE_CYCLES-1 -> cnt++.
//               cnt == SETTLE_CYCLES-1 -> evaluate keys_q:
//                 0 keys low -> IDLE, no output (glitch or early release).
//                 1 key low  -> load (see below) -> WAIT_REL.
//                 >=2 low    -> multi_err=1 for one cycle, nothing loaded -> WAIT_REL.
//   - WAIT_REL: stays until keys_q == all 1, then -> IDLE.
//               New presses and chords seen in WAIT_REL are ignored (no code, no multi_err).
//   Load condition: code_valid==0, or a transfer happens on the same edge.
//     code <= index of the low key; code_valid <= 1.
//     If the register is full and no transfer occurs: code is unchanged, overrun <= 1 (sticky).
//   Latency: key low sampled into keys_q at edge E0; code_valid rises at edge E0+SETTLE_CYCLES+1.
//     With defaults this is E3.
//   Handshake: when code_valid & code_ready with no same-edge load, code_valid falls at that edge.
//     code_ready while code_valid=0 has no effect. code never changes while code_valid=1 except on a transfer edge.
//   overrun: set has priority over clr_overrun on the same edge.
//   Holding a key produces exactly one keystroke; auto-repeat does not exist.
//   rst_n low at any point, including mid-SETTLE: immediate return to reset values.
//     A key still held at release of reset is treated as a new press.
// STRUCTURE
//   Header keypad_defs.vh: FSM state encodings (ST_IDLE/ST_SETTLE/ST_WAIT_REL), default N_KEYS, CODE_W, SETTLE_CYCLES.
//     The same header is shared with the downstream control FSM.
//   Sub-module key_scan (combinational), inputs keys_q, outputs:
//     low_cnt: 2 bits, saturates at 2.
//     low_idx: CODE_W bits, index of the lowest-numbered low key.
//   keypad_encoder holds the input register, FSM, counter, output register and flags.
// TESTING  (defaults, code_ready=1 unless stated)
//   1. keys_n[7]=0 for 10 cycles, then all 1 -> code=7, code_valid for 1 cycle at E0+3; exactly one keystroke; busy falls after release.
//   2. keys_n[3] low for 1 cycle only -> at evaluation 0 keys low: no code_valid, no multi_err, FSM returns to IDLE.
//   3. keys_n[2] and keys_n[5] low together -> one multi_err pulse, code_valid stays 0, WAIT_REL until both released.
//   4. code_ready=0: press 4, release, press 9 -> code=4 held with valid, overrun=1. clr_overrun -> overrun=0. code_ready=1 -> code 4 consumed.
//   5. code_valid=1 with code_ready asserted on the same edge as a new load (press 1 then press 6) -> code becomes 6, valid stays 1, no overrun.
//   6. rst_n pulsed low during SETTLE of key 0 -> all outputs 0 at once; key held across reset -> code=0 at E0+3 after reset release.

Source files
------------

// File: rtl/keypad_encoder_pkg.sv
// Shared definitions for the keypad encoder path: FSM state encodings and default sizing.
// The downstream control FSM imports the same package so both sides agree on encodings.
package keypad_encoder_pkg;

  localparam int N_KEYS_DEF        = 10;
  localparam int CODE_W_DEF        = 4;
  localparam int SETTLE_CYCLES_DEF = 2;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SETTLE   = 2'd1,
    ST_WAIT_REL = 2'd2
  } state_t;

  // Settle counter width; a one-cycle window still needs a 1-bit counter.
  function automatic int settle_cnt_w(input int settle_cycles);
    return (settle_cycles > 1) ? $clog2(settle_cycles) : 1;
  endfunction

endpackage

// File: rtl/keypad_encoder_key_scan.sv
// Combinational scan of the registered key levels: how many keys are low (saturating at 2)
// and which low key has the lowest index.
module key_scan
  import keypad_encoder_pkg::*;
#(
  parameter int N_KEYS = N_KEYS_DEF,
  parameter int CODE_W = CODE_W_DEF
) (
  input  logic [N_KEYS-1:0] keys_q,
  output logic [1:0]        low_cnt,
  output logic [CODE_W-1:0] low_idx
);

  always_comb begin
    low_cnt = 2'd0;
    low_idx = '0;
    // Descending walk so the last hit, i.e. the lowest index, wins.
    for (int i = N_KEYS - 1; i >= 0; i--) begin
      if (!keys_q[i]) begin
        low_idx = CODE_W'(i);
      end
    end
    for (int i = 0; i < N_KEYS; i++) begin
      if (!keys_q[i] && (low_cnt != 2'd2)) begin
        low_cnt = low_cnt + 2'd1;
      end
    end
  end

endmodule

// File: rtl/keypad_encoder.sv
// Keystroke encoder: turns debounced active-low key levels into one digit code per press,
// with a settle window, chord rejection and a single-entry valid/ready output register.
module keypad_encoder
  import keypad_encoder_pkg::*;
#(
  parameter int N_KEYS        = N_KEYS_DEF,
  parameter int CODE_W        = CODE_W_DEF,
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] keys_n,
  output logic [CODE_W-1:0] code,
  output logic              code_valid,
  input  logic              code_ready,
  output logic              multi_err,
  output logic              overrun,
  input  logic              clr_overrun,
  output logic              busy
);

  localparam int               CNT_W    = settle_cnt_w(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  logic [N_KEYS-1:0] keys_q;
  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [1:0]        low_cnt;
  logic [CODE_W-1:0] low_idx;
  logic              any_low;
  logic              eval;
  logic              xfer;
  logic              load_ok;
  logic              load;
  logic              drop;
  logic              chord;

  // Input register stage: source is already synchronous to clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      keys_q <= '1;
    end else begin
      keys_q <= keys_n;
    end
  end

  key_scan #(
    .N_KEYS (N_KEYS),
    .CODE_W (CODE_W)
  ) u_key_scan (
    .keys_q  (keys_q),
    .low_cnt (low_cnt),
    .low_idx (low_idx)
  );

  assign any_low = ~&keys_q;

  // FSM stage: state and settle counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    eval      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (any_low) begin
          state_nxt = ST_SETTLE;
          cnt_nxt   = '0;
        end
      end
      ST_SETTLE: begin
        if (cnt != CNT_LAST) begin
          cnt_nxt = cnt + 1'b1;
        end else begin
          eval      = 1'b1;
          // Nothing low at evaluation is a glitch or early release: no keystroke.
          state_nxt = (low_cnt == 2'd0) ? ST_IDLE : ST_WAIT_REL;
        end
      end
      ST_WAIT_REL: begin
        if (!any_low) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  assign busy = (state != ST_IDLE);

  // A load may reuse the register on the same edge the consumer takes the old code.
  assign xfer    = code_valid & code_ready;
  assign load_ok = ~code_valid | code_ready;
  assign load    = eval & (low_cnt == 2'd1) & load_ok;
  assign drop    = eval & (low_cnt == 2'd1) & ~load_ok;
  assign chord   = eval & (low_cnt == 2'd2);

  // Output register stage: code/valid handshake and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code       <= '0;
      code_valid <= 1'b0;
      multi_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      multi_err <= chord;
      if (load) begin
        code       <= low_idx;
        code_valid <= 1'b1;
      end else if (xfer) begin
        code_valid <= 1'b0;
      end
      if (drop) begin
        overrun <= 1'b1;
      end else if (clr_overrun) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_keypad_encoder.sv
// Bench for keypad_encoder: directed scenarios with literal expectations, then randomized
// key episodes checked every cycle against an event-timestamp reference model.
module tb_keypad_encoder;

  localparam int N  = 10;
  localparam int CW = 4;
  localparam int S  = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  keys_n = '1;
  logic [CW-1:0] code;
  logic          code_valid;
  logic          code_ready = 1'b1;
  logic          multi_err;
  logic          overrun;
  logic          clr_overrun = 1'b0;
  logic          busy;

  int n_cmp = 0;
  int n_err = 0;

  keypad_encoder #(
    .N_KEYS        (N),
    .CODE_W        (CW),
    .SETTLE_CYCLES (S)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .keys_n      (keys_n),
    .code        (code),
    .code_valid  (code_valid),
    .code_ready  (code_ready),
    .multi_err   (multi_err),
    .overrun     (overrun),
    .clr_overrun (clr_overrun),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: tracks when the next evaluation is due and whether a release is awaited.
  logic [N-1:0] m_kq = '1;
  int  edge_cnt  = 0;
  int  eval_edge = -1;
  bit  holding   = 0;
  bit  m_valid   = 0;
  int  m_code    = 0;
  bit  m_multi   = 0;
  bit  m_ovr     = 0;

  function automatic int lowest_low(input logic [N-1:0] kq);
    for (int i = 0; i < N; i++) if (!kq[i]) return i;
    return 0;
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_kq = '1; eval_edge = -1; holding = 0;
        m_valid = 0; m_code = 0; m_multi = 0; m_ovr = 0;
      end else begin
        int  lows;
        bit  xfer, loaded, ovr_set;
        lows    = $countones(~m_kq);
        xfer    = m_valid && code_ready;
        loaded  = 0;
        ovr_set = 0;
        m_multi = 0;
        if (eval_edge == edge_cnt) begin
          eval_edge = -1;
          if (lows == 1) begin
            if (!m_valid || code_ready) begin
              m_code = lowest_low(m_kq); m_valid = 1; loaded = 1;
            end else begin
              ovr_set = 1;
            end
          end
          if (lows >= 2) m_multi = 1;
          holding = (lows >= 1);
        end else if (holding) begin
          if (lows == 0) holding = 0;
        end else if (eval_edge < 0 && lows != 0) begin
          eval_edge = edge_cnt + S;
        end
        if (xfer && !loaded) m_valid = 0;
        if (ovr_set) m_ovr = 1;
        else if (clr_overrun) m_ovr = 0;
        m_kq = keys_n;
      end
      edge_cnt++;
    end
  end

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk("code_valid", code_valid, m_valid);
      chk("code", code, m_code);
      chk("multi_err", multi_err, m_multi);
      chk("overrun", overrun, m_ovr);
      chk("busy", busy, ((eval_edge >= 0) || holding));
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [N-1:0] press(input int k);
    logic [N-1:0] v;
    v = '1;
    v[k] = 1'b0;
    return v;
  endfunction

  initial begin
    // Reset values
    tick(2);
    chk("rst_code", code, 0);
    chk("rst_valid", code_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovr", overrun, 0);
    rst_n = 1'b1;
    tick(2);

    // Single key 7 held 10 cycles
    keys_n = press(7);
    tick(3);
    chk("t1_valid_early", code_valid, 0);
    tick(1);
    chk("t1_valid_e3", code_valid, 1);
    chk("t1_code", code, 7);
    tick(1);
    chk("t1_valid_e4", code_valid, 0);
    tick(5);
    keys_n = '1;
    tick(2);
    chk("t1_busy_rel", busy, 0);

    // One-cycle glitch on key 3
    keys_n = press(3);
    tick(1);
    keys_n = '1;
    tick(3);
    chk("t2_valid", code_valid, 0);
    chk("t2_multi", multi_err, 0);
    chk("t2_busy", busy, 0);
    tick(2);

    // Chord 2+5
    keys_n = press(2) & press(5);
    tick(4);
    chk("t3_multi", multi_err, 1);
    chk("t3_valid", code_valid, 0);
    tick(1);
    chk("t3_multi_pulse", multi_err, 0);
    keys_n = press(2);
    tick(3);
    chk("t3_busy_hold", busy, 1);
    keys_n = '1;
    tick(2);
    chk("t3_busy_rel", busy, 0);

    // Full register: overrun and clear
    code_ready = 1'b0;
    keys_n = press(4); tick(4);
    keys_n = '1;       tick(3);
    keys_n = press(9); tick(5);
    keys_n = '1;       tick(3);
    chk("t4_code", code, 4);
    chk("t4_valid", code_valid, 1);
    chk("t4_ovr", overrun, 1);
    clr_overrun = 1'b1; tick(1); clr_overrun = 1'b0;
    chk("t4_ovr_clr", overrun, 0);
    code_ready = 1'b1; tick(1); code_ready = 1'b0;
    chk("t4_consumed", code_valid, 0);

    // Transfer and load on the same edge
    keys_n = press(1); tick(4);
    chk("t5_code1", code, 1);
    keys_n = '1;       tick(3);
    keys_n = press(6); tick(3);
    code_ready = 1'b1; tick(1); code_ready = 1'b0;
    chk("t5_code6", code, 6);
    chk("t5_valid", code_valid, 1);
    chk("t5_ovr", overrun, 0);
    keys_n = '1; tick(3);
    code_ready = 1'b1; tick(1);

    // Reset during SETTLE with the key held through it
    keys_n = press(0);
    tick(2);
    rst_n = 1'b0;
    #1;
    chk("t6_valid", code_valid, 0);
    chk("t6_busy", busy, 0);
    chk("t6_multi", multi_err, 0);
    tick(2);
    rst_n = 1'b1;
    tick(3);
    chk("t6_valid_early", code_valid, 0);
    tick(1);
    chk("t6_valid", code_valid, 1);
    chk("t6_code", code, 0);
    keys_n = '1;
    tick(3);

    // Randomized episodes
    for (int ep = 0; ep < 300; ep++) begin
      int kind, hold, gap, a, b;
      kind = $urandom_range(0, 9);
      a    = $urandom_range(0, N - 1);
      b    = (a + $urandom_range(1, N - 1)) % N;
      hold = (kind == 8) ? 1 : $urandom_range(1, 7);
      gap  = $urandom_range(0, 4);
      if (kind <= 5)      keys_n = press(a);
      else if (kind <= 8) keys_n = (kind == 8) ? press(a) : (press(a) & press(b));
      else                keys_n = '1;
      for (int c = 0; c < hold; c++) begin
        code_ready  = ($urandom_range(0, 99) < 60);
        clr_overrun = ($urandom_range(0, 99) < 4);
        if ($urandom_range(0, 99) < 8) keys_n[$urandom_range(0, N - 1)] = 1'b0;
        tick(1);
      end
      keys_n = '1;
      for (int c = 0; c < gap; c++) begin
        code_ready  = ($urandom_range(0, 99) < 60);
        clr_overrun = ($urandom_range(0, 99) < 4);
        tick(1);
      end
      if ($urandom_range(0, 99) < 2) begin
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
      end
    end
    clr_overrun = 1'b0;
    code_ready  = 1'b1;
    tick(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
